// File: rtl/saradc_11b_dig_pkg.sv
// Shared types and constants for the 11-bit SAR ADC digital core.
//   conv_state_t   : conversion sequencer FSM states
//   step_cnt_w()   : width of the shared SAMPLE/CONV step counter
//   *_DEF          : default phase lengths
package saradc_11b_dig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SAMPLE,
    ST_HOLD,
    ST_CONV,
    ST_CAPT
  } conv_state_t;

  localparam int SAMPLE_CYC_DEF = 8;
  localparam int LDO_WAIT_DEF   = 64;

  // The step counter only has to reach (longest phase - 1).
  function automatic int step_cnt_w(input int sample_cyc, input int sar_msb);
    int longest;
    int w;
    longest = (sample_cyc > 2 * (sar_msb + 1)) ? sample_cyc : 2 * (sar_msb + 1);
    w       = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/saradc_11b_dig_adif_if.sv
// Digital <-> analog macro interface of the SAR ADC.
//   mp modport: digital side drives every strobe/enable and reads back sar.
interface saradc_11b_dig_adif_if #(
  parameter int N_CHANNELS = 16,
  parameter int SAR_MSB    = 12,
  parameter int CAL_MSB    = 5
);
  logic                  enable;
  logic                  en_vain_lv;
  logic                  release_ldo;
  logic                  cp_clk_ldo;
  logic                  sar_res;
  logic                  comp_res;
  logic                  track_res;
  logic [N_CHANNELS-1:0] sample_ch;
  logic                  refe;
  logic                  sar_clk;
  logic [SAR_MSB:0]      sar;
  logic [CAL_MSB:0]      cal;
  logic [2:0]            sesp_del;
  logic                  set_sar;
  logic                  set_track;
  logic                  ocs;
  logic                  scab_clk;
  logic                  lowsup;
  logic [SAR_MSB:0]      din_n;
  logic [SAR_MSB:0]      trackin_n;

  modport mp (
    output enable, en_vain_lv, release_ldo, cp_clk_ldo,
    output sar_res, comp_res, track_res, sample_ch, refe, sar_clk,
    output cal, sesp_del, set_sar, set_track, ocs, scab_clk, lowsup,
    output din_n, trackin_n,
    input  sar
  );
endinterface

// File: rtl/saradc_11b_dig_ldo_ctrl.sv
// Analog power-up control: registered enable, LDO settle counter with
// sticky release, and the charge-pump clock divider (period 4 clk).
//   en_i          : power enable request
//   enable_o      : registered enable (also used for en_vain_lv)
//   release_ldo_o : high LDO_WAIT cycles after enable_o rises, held
//   cp_clk_ldo_o  : divided clock, 0 whenever enable_o is 0
module saradc_11b_dig_ldo_ctrl
  import saradc_11b_dig_pkg::*;
#(
  parameter int LDO_WAIT = LDO_WAIT_DEF
) (
  input  logic clk_i,
  input  logic res_n_i,
  input  logic en_i,
  output logic enable_o,
  output logic release_ldo_o,
  output logic cp_clk_ldo_o
);
  localparam int CNT_W = $clog2(LDO_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic enable_q, enable_d;
  logic release_q, release_d;
  logic phase_q, phase_d;
  logic cp_q, cp_d;

  // Everything is decoded from en_i (not enable_q) so that all power
  // outputs drop on the same edge.
  always_comb begin
    enable_d  = en_i;
    cnt_d     = '0;
    release_d = 1'b0;
    phase_d   = 1'b0;
    cp_d      = 1'b0;
    if (en_i) begin
      cnt_d     = (cnt_q == CNT_W'(LDO_WAIT)) ? cnt_q : cnt_q + 1'b1;
      release_d = release_q | (cnt_q == CNT_W'(LDO_WAIT));
      phase_d   = ~phase_q;
      cp_d      = phase_q ? ~cp_q : cp_q;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      release_q <= 1'b0;
      phase_q   <= 1'b0;
      cp_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      release_q <= release_d;
      phase_q   <= phase_d;
      cp_q      <= cp_d;
    end
  end

  assign enable_o      = enable_q;
  assign release_ldo_o = release_q;
  assign cp_clk_ldo_o  = cp_q;

endmodule

// File: rtl/saradc_11b_dig_conv_seq.sv
// Conversion sequencer of the 11-bit SAR ADC digital core.
// Accepts one channel request at a time, runs RST/SAMPLE/HOLD/CONV/CAPT on
// the analog macro and returns the SAR word with a one-cycle valid strobe.
//   clk_i/res_n_i : clock, async active-low reset
//   en_i          : ADC power enable (dropping it aborts a conversion)
//   req_i/ch_i    : request, accepted when req_i & ready_o
//   cal_i/sesp_del_i : trims passed straight to the macro
//   ready_o/busy_o/valid_o/result_o/err_o : status and result
//   adif          : analog macro interface
module saradc_11b_dig_conv_seq
  import saradc_11b_dig_pkg::*;
#(
  parameter int N_CHANNELS = 16,
  parameter int SAR_MSB    = 12,
  parameter int CAL_MSB    = 5,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int LDO_WAIT   = LDO_WAIT_DEF
) (
  input  logic                          clk_i,
  input  logic                          res_n_i,
  input  logic                          en_i,
  input  logic                          req_i,
  input  logic [$clog2(N_CHANNELS)-1:0] ch_i,
  input  logic [CAL_MSB:0]              cal_i,
  input  logic [2:0]                    sesp_del_i,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic                          valid_o,
  output logic [SAR_MSB:0]              result_o,
  output logic                          err_o,
  saradc_11b_dig_adif_if.mp             adif
);
  localparam int CH_W     = $clog2(N_CHANNELS);
  localparam int STEP_W   = step_cnt_w(SAMPLE_CYC, SAR_MSB);
  localparam int CONV_CYC = 2 * (SAR_MSB + 1);

  conv_state_t           state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [SAR_MSB:0]      result_q, result_d;
  logic                  rst_pulse_q, rst_pulse_d;
  logic [N_CHANNELS-1:0] sample_ch_q, sample_ch_d;
  logic                  refe_q, refe_d;
  logic                  sar_clk_q, sar_clk_d;

  logic enable, release_ldo, cp_clk_ldo;
  logic accept;

  saradc_11b_dig_ldo_ctrl #(.LDO_WAIT(LDO_WAIT)) u_ldo_ctrl (
    .clk_i         (clk_i),
    .res_n_i       (res_n_i),
    .en_i          (en_i),
    .enable_o      (enable),
    .release_ldo_o (release_ldo),
    .cp_clk_ldo_o  (cp_clk_ldo)
  );

  // Registered enable (not en_i) keeps ready_o up in the cycle en_i falls,
  // so a request there is accepted and then aborted on the next edge.
  assign ready_o = (state_q == ST_IDLE) & enable & release_ldo;
  assign busy_o  = (state_q != ST_IDLE);
  assign accept  = req_i & ready_o;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (int'(ch_i) >= N_CHANNELS) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RST;
            ch_d    = ch_i;
          end
        end
      end
      ST_RST: begin
        state_d = ST_SAMPLE;
        step_d  = '0;
      end
      ST_SAMPLE: begin
        if (step_q == STEP_W'(SAMPLE_CYC - 1)) begin
          state_d = ST_HOLD;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_CONV;
        step_d  = '0;
      end
      ST_CONV: begin
        if (step_q == STEP_W'(CONV_CYC - 1)) begin
          state_d = ST_CAPT;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_CAPT: begin
        state_d  = ST_IDLE;
        valid_d  = 1'b1;
        result_d = adif.sar;
      end
      default: state_d = ST_IDLE;
    endcase

    // Power loss overrides any progress, including the capture itself.
    if ((state_q != ST_IDLE) && !en_i) begin
      state_d  = ST_IDLE;
      step_d   = '0;
      valid_d  = 1'b0;
      err_d    = 1'b1;
      result_d = result_q;
    end

    // Macro strobes are decoded from the next state so their flops line up
    // exactly with state_q.
    rst_pulse_d = (state_d == ST_RST);
    sample_ch_d = (state_d == ST_SAMPLE) ? (N_CHANNELS'(1) << ch_d) : '0;
    refe_d      = (state_d == ST_SAMPLE) || (state_d == ST_HOLD) || (state_d == ST_CONV);
    sar_clk_d   = (state_d == ST_CONV) && !step_d[0];
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      ch_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      rst_pulse_q <= 1'b0;
      sample_ch_q <= '0;
      refe_q      <= 1'b0;
      sar_clk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ch_q        <= ch_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      result_q    <= result_d;
      rst_pulse_q <= rst_pulse_d;
      sample_ch_q <= sample_ch_d;
      refe_q      <= refe_d;
      sar_clk_q   <= sar_clk_d;
    end
  end

  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign result_o = result_q;

  assign adif.enable      = enable;
  assign adif.en_vain_lv  = enable;
  assign adif.release_ldo = release_ldo;
  assign adif.cp_clk_ldo  = cp_clk_ldo;
  assign adif.sar_res     = rst_pulse_q;
  assign adif.comp_res    = rst_pulse_q;
  assign adif.track_res   = rst_pulse_q;
  assign adif.sample_ch   = sample_ch_q;
  assign adif.refe        = refe_q;
  assign adif.sar_clk     = sar_clk_q;
  assign adif.cal         = cal_i;
  assign adif.sesp_del    = sesp_del_i;
  assign adif.set_sar     = 1'b0;
  assign adif.set_track   = 1'b0;
  assign adif.ocs         = 1'b0;
  assign adif.scab_clk    = 1'b0;
  assign adif.lowsup      = 1'b0;
  assign adif.din_n       = '1;
  assign adif.trackin_n   = '1;

endmodule

// File: tb/tb_saradc_11b_dig_conv_seq.sv
// Directed bench for the SAR ADC conversion sequencer. A second instance
// with 12 channels exercises the out-of-range request path.
module tb_saradc_11b_dig_conv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n, en, req, req2;
  logic [3:0]  ch, ch2;
  logic [5:0]  cal;
  logic [2:0]  sesp;
  logic [12:0] sar_model;

  logic        ready, busy, valid, err;
  logic [12:0] result;
  logic        ready2, busy2, valid2, err2;
  logic [12:0] result2;

  saradc_11b_dig_adif_if #(.N_CHANNELS(16), .SAR_MSB(12), .CAL_MSB(5)) adif1 ();
  saradc_11b_dig_adif_if #(.N_CHANNELS(12), .SAR_MSB(12), .CAL_MSB(5)) adif2 ();

  assign adif1.sar = sar_model;
  assign adif2.sar = 13'h1FFF;

  saradc_11b_dig_conv_seq #(.N_CHANNELS(16)) dut (
    .clk_i(clk), .res_n_i(res_n), .en_i(en), .req_i(req), .ch_i(ch),
    .cal_i(cal), .sesp_del_i(sesp), .ready_o(ready), .busy_o(busy),
    .valid_o(valid), .result_o(result), .err_o(err), .adif(adif1)
  );

  saradc_11b_dig_conv_seq #(.N_CHANNELS(12)) dut2 (
    .clk_i(clk), .res_n_i(res_n), .en_i(en), .req_i(req2), .ch_i(ch2),
    .cal_i(cal), .sesp_del_i(sesp), .ready_o(ready2), .busy_o(busy2),
    .valid_o(valid2), .result_o(result2), .err_o(err2), .adif(adif2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   samp_n, first_samp, clk_rise, valid_n, valid_at, first_a, first_b, w;
  logic prev_clk, nz2, v2;
  int   e2;

  initial begin
    res_n = 1'b0; en = 1'b0; req = 1'b0; req2 = 1'b0;
    ch = 4'd0; ch2 = 4'd0; cal = 6'h2A; sesp = 3'h5; sar_model = 13'h0ABC;
    tick(); tick();

    // Reset state
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_enable", adif1.enable, 0);
    chk("rst_release", adif1.release_ldo, 0);
    chk("rst_sample_ch", adif1.sample_ch, 0);
    chk("rst_sar_res", adif1.sar_res, 0);
    chk("rst_din_n", adif1.din_n, 13'h1FFF);
    chk("rst_trackin_n", adif1.trackin_n, 13'h1FFF);
    chk("cal_pass", adif1.cal, 6'h2A);
    chk("sesp_pass", adif1.sesp_del, 3'h5);
    chk("const_ocs", adif1.ocs, 0);
    chk("const_set_sar", adif1.set_sar, 0);

    // Power-up: release and ready 64 cycles after enable
    res_n = 1'b1;
    tick();
    en = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      tick();
      if (k < 8) chk("cp_clk_ldo", adif1.cp_clk_ldo, ((k + 1) >> 1) & 1);
      if (k == 0) chk("enable_on", adif1.enable, 1);
      if (k == 63) begin
        chk("release_early", adif1.release_ldo, 0);
        chk("ready_early", ready, 0);
      end
      if (k == 64) begin
        chk("release_on", adif1.release_ldo, 1);
        chk("ready_on", ready, 1);
        chk("en_vain_lv", adif1.en_vain_lv, 1);
      end
    end

    // Conversion on channel 5
    ch = 4'd5; req = 1'b1;
    tick();
    req = 1'b0;
    chk("conv_busy", busy, 1);
    chk("conv_sar_res", adif1.sar_res, 1);
    chk("conv_ready_low", ready, 0);
    samp_n = 0; first_samp = -1; clk_rise = 0; valid_n = 0; valid_at = -1; prev_clk = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (adif1.sample_ch == 16'h0020) begin
        samp_n++;
        if (first_samp < 0) first_samp = k;
      end
      if (adif1.sar_clk && !prev_clk) clk_rise++;
      prev_clk = adif1.sar_clk;
      if (valid) begin
        valid_n++;
        valid_at = k;
      end
    end
    chk("sample_cycles", samp_n, 8);
    chk("sample_start", first_samp, 1);
    chk("sar_clk_pulses", clk_rise, 13);
    chk("valid_count", valid_n, 1);
    chk("valid_latency", valid_at, 37);
    chk("result_5", result, 13'h0ABC);
    chk("idle_after", busy, 0);

    // Out-of-range channel on the 12-channel instance
    chk("oor_ready", ready2, 1);
    ch2 = 4'd12; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    chk("oor_err", err2, 1);
    chk("oor_busy", busy2, 0);
    nz2 = 1'b0; v2 = 1'b0; e2 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nz2 = nz2 | (|adif2.sample_ch);
      v2  = v2 | valid2;
      e2  = e2 + int'(err2);
    end
    chk("oor_no_sample", nz2, 0);
    chk("oor_no_valid", v2, 0);
    chk("oor_err_1cyc", e2, 0);

    // Abort during CONV step 7
    sar_model = 13'h1555; ch = 4'd3; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (17) tick();
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_refe", adif1.refe, 1);
    en = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 1);
    chk("abort_valid", valid, 0);
    chk("abort_result", result, 13'h0ABC);
    chk("abort_release", adif1.release_ldo, 0);
    chk("abort_refe", adif1.refe, 0);
    tick();
    chk("abort_err_end", err, 0);
    chk("abort_no_valid", valid, 0);

    // Back-to-back: ch 0 then ch 15 with req held high
    en = 1'b1;
    w = 0;
    while (!ready && w < 100) begin
      tick();
      w++;
    end
    chk("relock_cycles", w, 65);
    sar_model = 13'h0123; ch = 4'd0; req = 1'b1;
    tick();
    ch = 4'd15;
    first_a = -1; first_b = -1; valid_at = -1;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (adif1.sample_ch == 16'h0001 && first_a < 0) first_a = k;
      if (adif1.sample_ch == 16'h8000 && first_b < 0) first_b = k;
      if (valid) begin
        valid_at = k;
        chk("b2b_result", result, 13'h0123);
      end
    end
    req = 1'b0;
    chk("b2b_first_sample", first_a, 1);
    chk("b2b_second_sample", first_b, 39);
    chk("b2b_valid", valid_at, 37);
    chk("b2b_mid_sample", adif1.sample_ch, 16'h8000);

    // Asynchronous reset mid-SAMPLE, no clock edge
    res_n = 1'b0;
    #1;
    chk("arst_sample_ch", adif1.sample_ch, 0);
    chk("arst_busy", busy, 0);
    chk("arst_refe", adif1.refe, 0);
    chk("arst_enable", adif1.enable, 0);
    chk("arst_release", adif1.release_ldo, 0);
    chk("arst_cp", adif1.cp_clk_ldo, 0);
    chk("arst_ready", ready, 0);
    chk("arst_err", err, 0);
    chk("arst_result", result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
